// File: rtl/psram_pkg.sv
// Shared constants and FSM state encoding for the QSPI PSRAM responder.
package psram_pkg;

  localparam logic [7:0]  CMD_QREAD    = 8'hEB;
  localparam logic [7:0]  CMD_QWRITE   = 8'h38;
  localparam int unsigned ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmd    = 3'd1,
    StAddr   = 3'd2,
    StWait   = 3'd3,
    StRdata  = 3'd4,
    StWdata  = 3'd5,
    StIgnore = 3'd6
  } psram_state_e;

endpackage

// File: rtl/psram_qspi_responder_if.sv
// QSPI pin bundle between a PSRAM controller (master) and the responder (slave).
interface psram_qspi_responder_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] douten;

  modport master (output sck, ce_n, din, input dout, douten);
  modport slave  (input sck, ce_n, din, output dout, douten);
endinterface

// File: rtl/sck_sync_edge.sv
// Two-flop synchroniser for the QSPI pins plus sck and ce_n edge pulses in the clk domain.
module sck_sync_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck_i,
  input  logic       ce_n_i,
  input  logic [3:0] din_i,
  output logic [3:0] din_o,
  output logic       ce_n_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       ce_fall_o,
  output logic       ce_rise_o
);

  logic       sck_meta_q, sck_sync_q, sck_prev_q;
  logic       ce_n_meta_q, ce_n_sync_q, ce_n_prev_q;
  logic [3:0] din_meta_q, din_sync_q;

  // din shares the sck pipeline depth so data lines up with the detected edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      ce_n_meta_q <= 1'b1;
      ce_n_sync_q <= 1'b1;
      ce_n_prev_q <= 1'b1;
      din_meta_q  <= 4'h0;
      din_sync_q  <= 4'h0;
    end else begin
      sck_meta_q  <= sck_i;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      ce_n_meta_q <= ce_n_i;
      ce_n_sync_q <= ce_n_meta_q;
      ce_n_prev_q <= ce_n_sync_q;
      din_meta_q  <= din_i;
      din_sync_q  <= din_meta_q;
    end
  end

  assign din_o      = din_sync_q;
  assign ce_n_o     = ce_n_sync_q;
  assign sck_rise_o = sck_sync_q & ~sck_prev_q;
  assign sck_fall_o = ~sck_sync_q & sck_prev_q;
  assign ce_fall_o  = ~ce_n_sync_q & ce_n_prev_q;
  assign ce_rise_o  = ce_n_sync_q & ~ce_n_prev_q;

endmodule

// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM responder: quad read (0xEB) and quad write (0x38) into an internal byte array.
module psram_qspi_responder
  import psram_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_CYCLES = 6
) (
  input logic                          clk,
  input logic                          rst,
  psram_qspi_responder_if.slave        qspi_io
);

  localparam int unsigned AW     = $clog2(MEM_BYTES);
  localparam int unsigned CntMax = (WAIT_CYCLES > 8) ? WAIT_CYCLES : 8;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CmdLast  = CntW'(7);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_NIBBLES - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  logic [3:0] din;
  logic       ce_n, sck_rise, sck_fall, ce_fall, ce_rise;

  sck_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .sck_i      (qspi_io.sck),
    .ce_n_i     (qspi_io.ce_n),
    .din_i      (qspi_io.din),
    .din_o      (din),
    .ce_n_o     (ce_n),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .ce_fall_o  (ce_fall),
    .ce_rise_o  (ce_rise)
  );

  psram_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [19:0]     shift_q, shift_d;
  logic            is_write_q, is_write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            nib_lo_q, nib_lo_d;
  logic [3:0]      wr_hi_q, wr_hi_d;
  logic [3:0]      dout_q, dout_d;
  logic [3:0]      douten_q, douten_d;
  logic [1:0]      settle_q, settle_d;

  logic [7:0]  mem [MEM_BYTES];
  logic        mem_we;
  logic [7:0]  rd_byte;
  logic [7:0]  opcode;
  logic [23:0] addr_full;
  logic        unused_addr_bits;

  assign rd_byte          = mem[addr_q];
  assign opcode           = {shift_q[6:0], din[0]};
  assign addr_full        = {shift_q, din};
  assign unused_addr_bits = ^addr_full[23:AW];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    nib_lo_d   = nib_lo_q;
    wr_hi_d    = wr_hi_q;
    dout_d     = dout_q;
    douten_d   = douten_q;
    mem_we     = 1'b0;
    // The synchronised ce_n still shows its reset value for two clocks; wait it out.
    settle_d   = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;

    if (ce_rise) begin
      state_d  = StIdle;
      cnt_d    = '0;
      nib_lo_d = 1'b0;
      douten_d = 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ce_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            shift_d = {shift_q[18:0], din[0]};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CmdLast) begin
              cnt_d = '0;
              if (opcode == CMD_QREAD) begin
                state_d    = StAddr;
                is_write_d = 1'b0;
              end else if (opcode == CMD_QWRITE) begin
                state_d    = StAddr;
                is_write_d = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            shift_d = addr_full[19:0];
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == AddrLast) begin
              cnt_d    = '0;
              addr_d   = addr_full[AW-1:0];
              nib_lo_d = 1'b0;
              if (is_write_q)            state_d = StWdata;
              else if (WAIT_CYCLES == 0) state_d = StRdata;
              else                       state_d = StWait;
            end
          end
        end
        StWait: begin
          if (sck_rise) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == WaitLast) begin
              cnt_d   = '0;
              state_d = StRdata;
            end
          end
        end
        StRdata: begin
          if (sck_fall) begin
            douten_d = 4'hF;
            nib_lo_d = ~nib_lo_q;
            if (nib_lo_q) begin
              dout_d = rd_byte[3:0];
              addr_d = addr_q + AW'(1);
            end else begin
              dout_d = rd_byte[7:4];
            end
          end
        end
        StWdata: begin
          if (sck_rise) begin
            if (nib_lo_q) begin
              mem_we   = 1'b1;
              addr_d   = addr_q + AW'(1);
              nib_lo_d = 1'b0;
            end else begin
              wr_hi_d  = din;
              nib_lo_d = 1'b1;
            end
          end
        end
        StIgnore: begin
          if (settle_q == 2'd2 && ce_n) state_d = StIdle;
        end
        default: state_d = StIgnore;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIgnore;
      cnt_q      <= '0;
      shift_q    <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      nib_lo_q   <= 1'b0;
      wr_hi_q    <= 4'h0;
      dout_q     <= 4'h0;
      douten_q   <= 4'h0;
      settle_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      nib_lo_q   <= nib_lo_d;
      wr_hi_q    <= wr_hi_d;
      dout_q     <= dout_d;
      douten_q   <= douten_d;
      settle_q   <= settle_d;
    end
  end

  // Contents survive reset; a byte completing on a reset clock is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr_q] <= {wr_hi_q, din};
  end

  assign qspi_io.dout   = dout_q;
  assign qspi_io.douten = douten_q;

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Randomised bench for psram_qspi_responder with a byte-array reference model.
module tb_psram_qspi_responder;

  localparam int MEM   = 1024;
  localparam int WAITC = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psram_qspi_responder_if bus ();

  psram_qspi_responder #(
    .MEM_BYTES   (MEM),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .qspi_io (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ev_cyc = 0;
  int         H = 2;
  bit         chk_on = 1'b0;
  logic [3:0] exp_dout = 4'h0;
  logic [3:0] exp_oe = 4'h0;
  logic [7:0] model_mem [MEM];
  logic [7:0] wr_q [$];
  logic [7:0] rd_q [$];

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int idx(logic [23:0] a, int i);
    return (int'(a[9:0]) + i) % MEM;
  endfunction

  // Outputs must settle within 3 clk of any pin event that changes them.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (chk_on && (cyc - ev_cyc >= 3)) begin
        check("douten", 8'(bus.douten), 8'(exp_oe));
        check("dout", 8'(bus.dout), 8'(exp_dout));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    ev_cyc = cyc;
  endtask

  task automatic sck_bit(logic [3:0] d);
    bus.sck = 1'b0;
    bus.din = d;
    clk_wait(H);
    bus.sck = 1'b1;
    clk_wait(H);
  endtask

  task automatic begin_tx(logic [7:0] op, logic [23:0] a, bit send_addr);
    bus.ce_n = 1'b0;
    clk_wait(3);
    for (int i = 7; i >= 0; i--) sck_bit({3'b000, op[i]});
    if (send_addr) for (int i = 5; i >= 0; i--) sck_bit(a[i*4 +: 4]);
  endtask

  task automatic end_tx();
    bus.ce_n = 1'b1;
    exp_oe   = 4'h0;
    mark();
    clk_wait(4);
    bus.sck = 1'b0;
    clk_wait(4);
  endtask

  task automatic wr_burst(logic [23:0] a);
    begin_tx(8'h38, a, 1'b1);
    for (int i = 0; i < wr_q.size(); i++) begin
      logic [7:0] b;
      b = wr_q[i];
      sck_bit(b[7:4]);
      sck_bit(b[3:0]);
      model_mem[idx(a, i)] = b;
    end
    end_tx();
  endtask

  task automatic rd_nibble(logic [3:0] nib, bit chk_rise, output logic [3:0] got);
    bus.sck  = 1'b0;
    exp_dout = nib;
    exp_oe   = 4'hF;
    mark();
    clk_wait(H);
    bus.sck = 1'b1;
    if (chk_rise) check("oe_at_rise", 8'(bus.douten), 8'h0F);
    clk_wait(H);
    got = bus.dout;
  endtask

  task automatic rd_burst(logic [23:0] a, int n);
    logic [3:0] hi, lo;
    logic [7:0] b;
    begin_tx(8'hEB, a, 1'b1);
    repeat (WAITC) sck_bit(4'h0);
    rd_q = {};
    for (int i = 0; i < n; i++) begin
      b = model_mem[idx(a, i)];
      rd_nibble(b[7:4], i > 0, hi);
      rd_nibble(b[3:0], 1'b1, lo);
      rd_q.push_back({hi, lo});
    end
    end_tx();
  endtask

  task automatic ignore_tx(logic [7:0] op);
    begin_tx(op, 24'h0, 1'b0);
    repeat (16) sck_bit(4'($urandom));
    end_tx();
  endtask

  initial begin
    logic [23:0] a;
    logic [7:0]  op;
    logic [7:0]  b;
    logic [3:0]  dummy;
    int          n;

    bus.sck  = 1'b0;
    bus.ce_n = 1'b1;
    bus.din  = 4'h0;
    clk_wait(4);
    rst = 1'b0;
    check("reset_douten", 8'(bus.douten), 8'h00);
    check("reset_dout", 8'(bus.dout), 8'h00);
    mark();
    chk_on = 1'b1;
    clk_wait(4);

    // Whole-array fill so every later read has a defined expectation.
    wr_q = {};
    for (int i = 0; i < MEM; i++) wr_q.push_back(8'($urandom));
    wr_burst(24'h0);

    wr_q = {8'hA5, 8'h3C};
    wr_burst(24'h000010);
    rd_burst(24'h000010, 2);
    check("basic_b0", rd_q[0], 8'hA5);
    check("basic_b1", rd_q[1], 8'h3C);

    wr_q = {8'h11, 8'h22};
    wr_burst(24'h0003FF);
    rd_burst(24'h0003FF, 2);
    check("wrap_3ff", rd_q[0], 8'h11);
    check("wrap_000", rd_q[1], 8'h22);
    rd_burst(24'h000000, 1);
    check("wrap_000_direct", rd_q[0], 8'h22);

    ignore_tx(8'h9F);
    rd_burst(24'h000010, 2);
    check("after_ignore_b0", rd_q[0], 8'hA5);
    check("after_ignore_b1", rd_q[1], 8'h3C);

    // Half a byte then deselect: nothing stored.
    b = model_mem[32'h20];
    begin_tx(8'h38, 24'h000020, 1'b1);
    sck_bit(4'h7);
    end_tx();
    rd_burst(24'h000020, 1);
    check("partial_unchanged", rd_q[0], b);
    wr_q = {8'h44};
    wr_burst(24'h000020);
    rd_burst(24'h000020, 1);
    check("write_44", rd_q[0], 8'h44);

    // Second nibble's sck rise coincides with ce_n rise: deselect wins.
    b = model_mem[32'h21];
    begin_tx(8'h38, 24'h000021, 1'b1);
    sck_bit(~b[7:4]);
    bus.sck = 1'b0;
    bus.din = ~b[3:0];
    clk_wait(H);
    bus.sck  = 1'b1;
    bus.ce_n = 1'b1;
    mark();
    clk_wait(4);
    bus.sck = 1'b0;
    clk_wait(4);
    rd_burst(24'h000021, 1);
    check("ce_priority", rd_q[0], b);

    // Reset while driving read data.
    begin_tx(8'hEB, 24'h000010, 1'b1);
    repeat (WAITC) sck_bit(4'h0);
    rd_nibble(4'hA, 1'b0, dummy);
    check("pre_rst_nib", 8'(dummy), 8'h0A);
    @(negedge clk);
    rst    = 1'b1;
    chk_on = 1'b0;
    @(posedge clk);
    #1;
    check("rst_douten", 8'(bus.douten), 8'h00);
    check("rst_dout", 8'(bus.dout), 8'h00);
    @(negedge clk);
    rst      = 1'b0;
    exp_oe   = 4'h0;
    exp_dout = 4'h0;
    mark();
    chk_on = 1'b1;
    repeat (8) sck_bit(4'($urandom));
    end_tx();
    rd_burst(24'h000010, 1);
    check("after_rst_read", rd_q[0], 8'hA5);

    // 16-byte bursts at two sck rates.
    for (int s = 0; s < 2; s++) begin
      H = (s == 0) ? 2 : 4;
      a = 24'($urandom);
      wr_q = {};
      for (int i = 0; i < 16; i++) wr_q.push_back(8'($urandom));
      wr_burst(a);
      rd_burst(a, 16);
      for (int i = 0; i < 16; i++) check("sweep_byte", rd_q[i], wr_q[i]);
    end

    for (int t = 0; t < 30; t++) begin
      H = $urandom_range(2, 4);
      a = 24'($urandom);
      n = $urandom_range(1, 6);
      case ($urandom_range(0, 2))
        0: begin
          wr_q = {};
          repeat (n) wr_q.push_back(8'($urandom));
          wr_burst(a);
        end
        1: begin
          rd_burst(a, n);
          for (int i = 0; i < n; i++) check("rand_rd", rd_q[i], model_mem[idx(a, i)]);
        end
        default: begin
          op = 8'($urandom);
          if (op == 8'hEB || op == 8'h38) op = 8'h00;
          ignore_tx(op);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_qspi_responder.md
PSRAM_QSPI_RESPONDER -- requirements
Module: psram_qspi_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, size of the internal byte array; must be a power of 2.
REQ-002 SHALL have parameter WAIT_CYCLES, default 6, dummy sck cycles between address and read data for 0xEB.
REQ-003 clk  in  1  system clock; must be at least 4x the sck frequency.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 sck  in  1  QSPI serial clock from the PSRAM controller (asynchronous to clk).
REQ-006 ce_n  in  1  chip enable, active-low; frames one transaction.
REQ-007 din  in  4  QSPI data lines as seen by the responder; cmd uses din[0] only.
REQ-008 dout  out  4  read data nibble.
REQ-009 douten  out  4  output enable per line; 4'hF while driving read data, else 4'h0.

Function
REQ-010 Synchronisation: sck, ce_n and din SHALL pass through a 2-flop synchroniser; sck rise and fall events are detected in the clk domain.
REQ-011 FSM states: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
REQ-012 IDLE -> CMD on synchronised ce_n falling; bit counter cleared.
REQ-013 CMD: 8 sck rises, sampling din[0] MSB first. Then 0xEB -> ADDR (read); 0x38 -> ADDR (write); any other opcode -> IGNORE.
REQ-014 ADDR: 6 sck rises capture 24-bit address, high nibble first. Then read -> WAIT (or RDATA if WAIT_CYCLES = 0); write -> WDATA.
REQ-015 WAIT: count WAIT_CYCLES sck rises, then -> RDATA.
REQ-016 RDATA: on each sck fall, drive the next nibble of mem[addr] on dout, high nibble first. Increment addr after the low nibble.
REQ-017 RDATA: the first nibble SHALL be driven at the first sck fall after entering RDATA.
REQ-018 RDATA: dout changes no later than 3 clk after the pin-level sck fall.
REQ-019 WDATA: on each sck rise, capture a nibble, high nibble first. Write mem[addr] on the second nibble, then increment addr.
REQ-020 Address use: only addr[log2(MEM_BYTES)-1:0] indexes memory. Increment wraps MEM_BYTES-1 -> 0; upper address bits are ignored.
REQ-021 Burst length is unbounded; the transaction ends only when ce_n goes high.
REQ-022 ce_n rising in any state SHALL force IDLE within 3 clk, with douten = 0 and counters cleared.
REQ-023 A partial write byte (one nibble captured) SHALL be discarded on ce_n rising.
REQ-024 IGNORE: douten held 0, no memory access, exit only on ce_n high.
REQ-025 If sck rise and ce_n rise are seen in the same clk, ce_n rise SHALL take priority: no capture, no write.
REQ-026 douten SHALL be 4'hF only in RDATA after the first nibble is driven; dout holds its last value otherwise.

Reset
REQ-027 On rst: state = IGNORE, dout = 4'h0, douten = 4'h0, all counters and address = 0, synchroniser flops = idle (sck 0, ce_n 1).
REQ-028 After rst the responder SHALL see ce_n high before accepting a command; a transaction in flight during reset is ignored.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 rst asserted mid-transaction SHALL abort it; a half-written byte is not stored.

Structure
REQ-031 Shared package psram_pkg SHALL hold CMD_QREAD = 8'hEB, CMD_QWRITE = 8'h38, ADDR_NIBBLES = 6 and the FSM state encoding.
REQ-032 One sub-module, sck_sync_edge, SHALL provide the 2-flop synchroniser plus sck rise/fall and ce_n rise/fall pulses.
REQ-033 Memory SHALL be an inferred reg array; a single write port and a single read port are sufficient.

Verification
REQ-034 Write 0x38, addr 0x000010, data 0xA5 0x3C, then ce_n high; read 0xEB, addr 0x000010 -> dout nibbles A,5,3,C after 6 dummy cycles, douten = F.
REQ-035 Write 0x38, addr 0x0003FF, data 0x11 0x22 (MEM_BYTES = 1024) -> mem[0x3FF] = 0x11, mem[0x000] = 0x22 (wrap).
REQ-036 Opcode 0x9F followed by 16 sck cycles -> douten stays 0, memory unchanged; next 0xEB transaction reads correctly.
REQ-037 Write 0x38, addr 0x20, one nibble 0x7, then ce_n high -> mem[0x20] unchanged; following full write 0x44 to 0x20 reads back 0x44.
REQ-038 Assert rst during RDATA at addr 0x10 -> douten = 0 next clk, ignored until ce_n high; a new read of 0x10 returns the stored value.
REQ-039 Sweep sck = clk/4 and clk/8 for a 16-byte burst write + read -> all bytes match; dout stable at every sck rise during RDATA.
